// File: rtl/stream_mem_writer_if.sv
// Byte-stream input and memory write-port signals of stream_mem_writer.
// slave : the writer's view (consumes the stream, drives the memory port).
// master: the surrounding logic's view (drives the stream, observes writes).
interface stream_mem_writer_if #(
    parameter int ADDR_W = 8
) ();
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_last;
    logic              s_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/stream_mem_writer.sv
// Captures a byte stream into memory as a length-prefixed array.
// The payload goes to BASE_ADDR+1 onwards. The count goes to BASE_ADDR once the
// message ends, or once MAX_LEN bytes have arrived (the capture is truncated).
//
// state | meaning
// IDLE  | waiting for start; the stream is not accepted
// RECV  | accepting bytes; each handshake produces one payload write
// WRLEN | issuing the length write and latching the length output
// DONE  | capture complete; done is raised in the following cycle
module stream_mem_writer #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int MAX_LEN   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    stream_mem_writer_if.slave   bus,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [7:0]           length
);
    typedef enum logic [1:0] {IDLE, RECV, WRLEN, DONE} state_t;

    localparam logic [8:0] MAX_CNT = 9'(MAX_LEN);

    state_t            state_q, state_d;
    logic [8:0]        count_q, count_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        length_q, length_d;
    logic              s_ready;
    logic              hs;

    // Ready is combinational so that the cycle after the final beat already reports 0.
    always_comb begin
        s_ready = (state_q == RECV) && (count_q < MAX_CNT);
        hs      = s_ready && bus.s_valid;
    end

    // Next-state and registered-output logic. In the first IDLE cycle after a
    // capture, done is still high; start is held off until that cycle has passed.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        overflow_d  = overflow_q;
        length_d    = length_q;
        case (state_q)
            IDLE: begin
                if (start && !done_q) begin
                    count_d    = 9'd0;
                    overflow_d = 1'b0;
                    length_d   = 8'd0;
                    state_d    = RECV;
                end
            end
            RECV: begin
                if (hs) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ADDR_W'(BASE_ADDR + 1 + int'(count_q));
                    mem_wdata_d = bus.s_data;
                    count_d     = count_q + 9'd1;
                    if (bus.s_last) begin
                        state_d = WRLEN;
                    end else if (count_d == MAX_CNT) begin
                        overflow_d = 1'b1;
                        state_d    = WRLEN;
                    end
                end
            end
            WRLEN: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = ADDR_W'(BASE_ADDR);
                mem_wdata_d = count_q[7:0];
                length_d    = count_q[7:0];
                state_d     = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Busy stays high through the done cycle.
        busy_d = (state_d != IDLE) || (state_q == DONE);
    end

    // State and output registers, with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= 9'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            length_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            length_q    <= length_d;
        end
    end

    assign bus.s_ready   = s_ready;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign overflow      = overflow_q;
    assign length        = length_q;
endmodule

// File: doc/stream_mem_writer.md
# stream_mem_writer

Receiving-side counterpart of the memory-streaming reader. Accepts a byte stream over a valid/ready handshake and stores it as a length-prefixed array: payload at `BASE_ADDR+1 … BASE_ADDR+N`, count `N` at `BASE_ADDR`. The reader consumes exactly this layout. The block sits between an upstream byte source and the shared single-port write side of the data memory.

## Interface
- `ADDR_W`, 8: memory address width.
- `BASE_ADDR`, 0: address of the length byte; payload starts at `BASE_ADDR+1`.
- `MAX_LEN`, 255: maximum payload beats, 1..255, with `BASE_ADDR+MAX_LEN < 2**ADDR_W`.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `start` in 1: one-cycle request to begin a capture; honoured only in IDLE.
- `s_valid` in 1: upstream byte valid.
- `s_data` in 8: upstream byte.
- `s_last` in 1: qualifies the final byte of the message.
- `s_ready` out 1: block accepts a byte this cycle.
- `mem_we` out 1: memory write strobe.
- `mem_addr` out `ADDR_W`: write address.
- `mem_wdata` out 8: write data.
- `busy` out 1: high from the cycle after `start` is accepted until `done`, inclusive.
- `done` out 1: one-cycle pulse after the length byte is written.
- `overflow` out 1: sticky flag; capture was truncated at `MAX_LEN`. Cleared by the next accepted `start`.
- `length` out 8: final count `N`, held from `done` until the next accepted `start`.

## Operation
- The FSM has four states: IDLE, RECV, WRLEN and DONE.
- **IDLE**: `s_ready`=0. On `start`, clear `count`, clear `overflow`, clear `length`, and go to RECV. All other inputs are ignored.
- **RECV**: `s_ready` = (`count` < `MAX_LEN`), combinational from state and count. A handshake is `s_valid && s_ready`. Each handshake:
  - registers a write with `mem_addr`=`BASE_ADDR+1+count` and `mem_wdata`=`s_data`;
  - increments `count` (9-bit internal, no wrap).
  - Exit to WRLEN when either condition holds:
    - the beat carries `s_last`; or
    - `count` becomes `MAX_LEN` without `s_last`. In this case set `overflow`=1. Further upstream bytes stay unconsumed, because `s_ready` is already 0.
- **WRLEN**: registers a write with `mem_addr`=`BASE_ADDR` and `mem_wdata`=`count[7:0]`. Also loads `length`. Then go to DONE.
- **DONE**: `done`=1 for this cycle only. Then go to IDLE.
- Zero-length messages do not exist. `s_last` always rides on a data byte.
- `start` while not IDLE is ignored and has no side effects.
- `s_last` with `s_valid`=0 is ignored.
- **Reset, including mid-capture**: FSM goes to IDLE. All outputs are driven 0: `s_ready`, `mem_we`, `mem_addr`, `mem_wdata`, `busy`, `done`, `overflow`, `length`. Partially written payload stays in memory. No length byte is written.

## Timing
- Reset values: every output is 0.
- `mem_we`, `mem_addr` and `mem_wdata` are registered. A handshake in cycle k produces `mem_we`=1 in cycle k+1 with the matching address and data. When no write is pending, `mem_we`=0 and `mem_addr`/`mem_wdata` hold their last values.
- `start` in cycle s: `busy`=1 and `s_ready`=1 from cycle s+1. The earliest possible handshake is in cycle s+1.
- Final beat accepted in cycle k:
  - payload write in k+1, and `s_ready`=0 from k+1;
  - length write (WRLEN) in k+2;
  - `done` and `length` valid in k+3;
  - `busy` falls in k+4;
  - a new `start` is honoured in k+4.
- Full-rate streaming is supported: one beat per cycle while `s_valid` stays high. Gaps in `s_valid` insert idle cycles with `mem_we`=0.
- The overflow path has the same latency from the `MAX_LEN`-th handshake.

## Test plan
- **Normal message**: `start`, then 120 beats with values 1..120, `s_valid` toggling every cycle, `s_last` on value 120.
  - Expect `mem[1..120]`=1..120 and `mem[0]`=120.
  - Expect `length`=120, `overflow`=0, and exactly one `done` pulse, 3 cycles after the last handshake.
- **Single beat**: one beat 8'hA5 with `s_last`.
  - Expect `mem[1]`=A5 at handshake+1 and `mem[0]`=1 at handshake+2.
  - Expect `done` at handshake+3 and `length`=1.
- **Overflow**: `MAX_LEN`=4; upstream presents 6 beats, none with `s_last`.
  - Expect 4 payload writes and `s_ready`=0 after the 4th handshake.
  - Expect `mem[0]`=4, `overflow`=1, and beats 5–6 still pending upstream.
  - Expect `overflow` to clear on the next `start`.
- **Reset mid-capture**: assert `reset` for one cycle after 10 accepted beats.
  - Expect all outputs 0 the following cycle, no write to `mem[0]`, and no `done`.
  - A fresh `start` then captures a 3-beat message correctly.
- **Protocol guards**:
  - `s_valid` held high before `start` → no handshake and no writes.
  - `start` pulsed during RECV → no restart, and `count` continues.
- **Round trip**: write 120 bytes (1..120) with this block, then run the reader on the same memory. The reader's `data_out` sequence must match 1..120 exactly.
